optimal_point_tracker: RTL and testbench

//  Registered, parametrised successor of the combinational optimal-point estimator in the om_est timing-recovery chain.

---
 rtl/optimal_point_tracker_pkg.sv | 28 ++
 rtl/optimal_point_tracker_if.sv | 31 +++
 rtl/optimal_point_tracker_wrap.sv | 44 ++++
 rtl/optimal_point_tracker.sv | 124 ++++++++++++
 tb/tb_optimal_point_tracker.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/optimal_point_tracker_pkg.sv
// Shared types and helpers for the optimal-point tracker: FSM states, eps scale
// constants as functions of the eps width, and ping-pong buffer index wrapping.
package optimal_point_tracker_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_ADJ  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // One sample of timing error in eps units, and half of it.
  function automatic int eps_one(input int eps_w);
    return 1 << (eps_w - 1);
  endfunction

  function automatic int eps_half(input int eps_w);
    return 1 << (eps_w - 2);
  endfunction

  // Index into the 2*seg_len ping-pong buffer; handles negative inputs.
  function automatic int wrap_idx(input int v, input int seg_len);
    int m;
    m = 2 * seg_len;
    return ((v % m) + m) % m;
  endfunction

endpackage

// File: rtl/optimal_point_tracker_if.sv
// Handshake bus of the optimal-point tracker: eps request side and result side.
interface optimal_point_tracker_if #(
  parameter int IDX_W   = 11,
  parameter int EPS_W   = 16,
  parameter int TIMES_W = 20
);
  logic                     eps_valid;
  logic                     eps_ready;
  logic signed [EPS_W-1:0]  eps_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [IDX_W-1:0]         esti_index;
  logic [IDX_W-1:0]         esti_index_next;
  logic [IDX_W-1:0]         interp_index;
  logic signed [EPS_W-1:0]  eps_out;
  logic                     adv;
  logic                     ret;
  logic [TIMES_W-1:0]       process_times;

  modport master (
    output eps_valid, eps_in, out_ready,
    input  eps_ready, out_valid, esti_index, esti_index_next, interp_index,
           eps_out, adv, ret, process_times
  );

  modport slave (
    input  eps_valid, eps_in, out_ready,
    output eps_ready, out_valid, esti_index, esti_index_next, interp_index,
           eps_out, adv, ret, process_times
  );
endinterface

// File: rtl/optimal_point_tracker_wrap.sv
// Combinational eps compare/wrap/clamp: wraps |eps| > HALF by one sample when
// index adjustment is allowed, otherwise clamps to +/-HALF.
module optimal_point_wrap
  import optimal_point_tracker_pkg::*;
#(
  parameter int EPS_W = 16
) (
  input  logic signed [EPS_W-1:0] eps,
  input  logic                    times_ok,
  output logic signed [EPS_W-1:0] eps_out,
  output logic                    adv,
  output logic                    ret
);
  localparam logic signed [EPS_W:0] ONE  = (EPS_W+1)'(eps_one(EPS_W));
  localparam logic signed [EPS_W:0] HALF = (EPS_W+1)'(eps_half(EPS_W));

  logic signed [EPS_W:0] e;
  logic signed [EPS_W:0] r;

  // One extra bit so eps +/- ONE never overflows before resizing.
  always_comb begin
    e   = {eps[EPS_W-1], eps};
    r   = e;
    adv = 1'b0;
    ret = 1'b0;
    if (e > HALF) begin
      if (times_ok) begin
        r   = e - ONE;
        adv = 1'b1;
      end else begin
        r = HALF;
      end
    end else if (e < -HALF) begin
      if (times_ok) begin
        r   = e + ONE;
        ret = 1'b1;
      end else begin
        r = -HALF;
      end
    end
    eps_out = r[EPS_W-1:0];
  end

endmodule

// File: rtl/optimal_point_tracker.sv
// Registered optimal-point tracker: IDLE->EVAL->ADJ->OUT per eps segment,
// tracking the sampling index into a 2*SEG_LEN ping-pong buffer.
module optimal_point_tracker
  import optimal_point_tracker_pkg::*;
#(
  parameter int SEG_LEN     = 1024,
  parameter int IDX_W       = 11,
  parameter int EPS_W       = 16,
  parameter int TIMES_W     = 20,
  parameter int MIN_TIMES   = 10,
  parameter int INTERP_BACK = 4,
  parameter int INIT_IDX    = 512
) (
  input logic                   clk,
  input logic                   rst,
  input logic                   clr,
  optimal_point_tracker_if.slave bus
);
  localparam logic [IDX_W-1:0] IDX0 = IDX_W'(INIT_IDX);

  state_t                  state;
  logic signed [EPS_W-1:0] eps_reg;
  logic signed [EPS_W-1:0] eps_prev;
  logic signed [EPS_W-1:0] w_eps;
  logic                    w_adv;
  logic                    w_ret;
  logic [IDX_W-1:0]        esti;
  logic signed [EPS_W-1:0] eps_out_r;
  logic                    adv_r;
  logic                    ret_r;
  logic [TIMES_W-1:0]      times;
  logic                    eps_ready_r;
  logic                    out_valid_r;

  logic signed [EPS_W-1:0] c_eps;
  logic                    c_adv;
  logic                    c_ret;
  logic                    times_ok;

  assign times_ok = (times >= TIMES_W'(MIN_TIMES));

  optimal_point_wrap #(.EPS_W(EPS_W)) u_wrap (
    .eps      (eps_reg),
    .times_ok (times_ok),
    .eps_out  (c_eps),
    .adv      (c_adv),
    .ret      (c_ret)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      eps_reg     <= '0;
      eps_prev    <= '0;
      w_eps       <= '0;
      w_adv       <= 1'b0;
      w_ret       <= 1'b0;
      esti        <= IDX0;
      eps_out_r   <= '0;
      adv_r       <= 1'b0;
      ret_r       <= 1'b0;
      times       <= '0;
      eps_ready_r <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (clr) begin
      // Restart acquisition; beats any accept or output handshake this cycle.
      state       <= S_IDLE;
      eps_prev    <= '0;
      esti        <= IDX0;
      eps_out_r   <= '0;
      adv_r       <= 1'b0;
      ret_r       <= 1'b0;
      times       <= '0;
      eps_ready_r <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.eps_valid) begin
          eps_reg     <= bus.eps_in;
          eps_ready_r <= 1'b0;
          state       <= S_EVAL;
        end
        S_EVAL: begin
          w_eps <= c_eps;
          w_adv <= c_adv;
          w_ret <= c_ret;
          state <= S_ADJ;
        end
        S_ADJ: begin
          if (w_adv)      esti <= IDX_W'(wrap_idx(int'(esti) + 1, SEG_LEN));
          else if (w_ret) esti <= IDX_W'(wrap_idx(int'(esti) - 1, SEG_LEN));
          eps_out_r   <= w_eps;
          adv_r       <= w_adv;
          ret_r       <= w_ret;
          if (times != '1) times <= times + 1'b1;
          eps_prev    <= eps_reg;
          out_valid_r <= 1'b1;
          state       <= S_OUT;
        end
        S_OUT: if (bus.out_ready) begin
          out_valid_r <= 1'b0;
          eps_ready_r <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // eps_prev is held for future discontinuity detection; nothing reads it yet.
  logic unused_eps_prev;
  assign unused_eps_prev = ^eps_prev;

  assign bus.eps_ready       = eps_ready_r;
  assign bus.out_valid       = out_valid_r;
  assign bus.esti_index      = esti;
  assign bus.esti_index_next = IDX_W'(wrap_idx(int'(esti) + SEG_LEN, SEG_LEN));
  assign bus.interp_index    = IDX_W'(wrap_idx(int'(esti) - INTERP_BACK, SEG_LEN));
  assign bus.eps_out         = eps_out_r;
  assign bus.adv             = adv_r;
  assign bus.ret             = ret_r;
  assign bus.process_times   = times;

endmodule

// File: tb/tb_optimal_point_tracker.sv
// Bench for optimal_point_tracker: reset, table vectors, randomized segments
// against a segment-level model, backpressure, index wrap, clr and async rst.
module tb_optimal_point_tracker;
  localparam int ONE  = 32768;
  localparam int HALF = 16384;
  localparam int NIDX = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  optimal_point_tracker_if #(.IDX_W(11), .EPS_W(16), .TIMES_W(20)) bus ();

  optimal_point_tracker dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ref_esti  = 512;
  int ref_times = 0;
  int exp_esti, exp_eo, exp_adv, exp_ret, exp_times;
  int got_esti, got_eo, got_adv, got_ret, got_times;

  typedef struct {
    int eps;
    int esti;
    int eo;
    int adv;
    int ret;
    int times;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Segment-level model: apply the decision rules to the tracked index/count.
  task automatic model_step(input int e);
    bit ok;
    ok = (ref_times >= 10);
    exp_adv = 0; exp_ret = 0; exp_eo = e;
    if (e > HALF) begin
      if (ok) begin ref_esti = (ref_esti + 1) % NIDX; exp_eo = e - ONE; exp_adv = 1; end
      else exp_eo = HALF;
    end else if (e < -HALF) begin
      if (ok) begin ref_esti = (ref_esti + NIDX - 1) % NIDX; exp_eo = e + ONE; exp_ret = 1; end
      else exp_eo = -HALF;
    end
    if (ref_times < (1 << 20) - 1) ref_times++;
    exp_esti  = ref_esti;
    exp_times = ref_times;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, " esti"},   int'(bus.esti_index),      exp_esti);
    chk({tag, " next"},   int'(bus.esti_index_next), (exp_esti + 1024) % NIDX);
    chk({tag, " interp"}, int'(bus.interp_index),    (exp_esti - 4 + NIDX) % NIDX);
    chk({tag, " eps_out"}, int'(bus.eps_out),        exp_eo);
    chk({tag, " adv"},    int'(bus.adv),             exp_adv);
    chk({tag, " ret"},    int'(bus.ret),             exp_ret);
    chk({tag, " times"},  int'(bus.process_times),   exp_times);
  endtask

  // One segment: offer eps, check 3-cycle latency, optional stall, handshake.
  task automatic xact(input string tag, input int e, input int stall, input bit hold);
    int n;
    model_step(e);
    @(negedge clk);
    bus.eps_valid = 1'b1;
    bus.eps_in    = 16'(e);
    n = 0;
    while (!bus.eps_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.eps_ready) begin
      chk({tag, " accept_timeout"}, 0, 1);
      bus.eps_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (hold) bus.eps_in = 16'(~e);
    else      bus.eps_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    chk({tag, " latency"}, n, 3);
    if (!bus.out_valid) begin bus.eps_valid = 1'b0; return; end
    for (int i = 0; i < stall; i++) begin
      chk_outputs(tag);
      chk({tag, " stall eps_ready"}, int'(bus.eps_ready), 0);
      chk({tag, " stall out_valid"}, int'(bus.out_valid), 1);
      @(negedge clk);
    end
    chk_outputs(tag);
    got_esti  = int'(bus.esti_index);
    got_eo    = int'(bus.eps_out);
    got_adv   = int'(bus.adv);
    got_ret   = int'(bus.ret);
    got_times = int'(bus.process_times);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.eps_valid = 1'b0;
    chk({tag, " post out_valid"}, int'(bus.out_valid), 0);
    chk({tag, " post eps_ready"}, int'(bus.eps_ready), 1);
  endtask

  task automatic quiet_check(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk({tag, " no out_valid"}, seen, 0);
  endtask

  initial begin
    int bnd[7];
    int e, guard;
    bnd = '{16384, 16385, -16384, -16385, 32767, -32768, 0};
    bus.eps_valid = 1'b0;
    bus.eps_in    = '0;
    bus.out_ready = 1'b0;

    tbl[0]  = '{ 20000, 512,  16384, 0, 0,  1};
    tbl[1]  = '{-20000, 512, -16384, 0, 0,  2};
    tbl[2]  = '{ 16384, 512,  16384, 0, 0,  3};
    tbl[3]  = '{ 20000, 512,  16384, 0, 0,  4};
    tbl[4]  = '{   100, 512,    100, 0, 0,  5};
    tbl[5]  = '{ 32767, 512,  16384, 0, 0,  6};
    tbl[6]  = '{-32768, 512, -16384, 0, 0,  7};
    tbl[7]  = '{-16384, 512, -16384, 0, 0,  8};
    tbl[8]  = '{     0, 512,      0, 0, 0,  9};
    tbl[9]  = '{ 17000, 512,  16384, 0, 0, 10};
    tbl[10] = '{ 20000, 513, -12768, 1, 0, 11};
    tbl[11] = '{-20000, 512,  12768, 0, 1, 12};
    tbl[12] = '{ 16385, 513, -16383, 1, 0, 13};
    tbl[13] = '{-16385, 512,  16383, 0, 1, 14};
    tbl[14] = '{ 32767, 513,     -1, 1, 0, 15};
    tbl[15] = '{-32768, 512,      0, 0, 1, 16};
    tbl[16] = '{  8000, 512,   8000, 0, 0, 17};

    // Reset state, during and after reset.
    repeat (3) @(negedge clk);
    chk("rst esti", int'(bus.esti_index), 512);
    rst = 1'b0;
    @(negedge clk);
    chk("rst eps_ready", int'(bus.eps_ready), 1);
    chk("rst out_valid", int'(bus.out_valid), 0);
    chk("rst esti_after", int'(bus.esti_index), 512);
    chk("rst next", int'(bus.esti_index_next), 1536);
    chk("rst interp", int'(bus.interp_index), 508);
    chk("rst times", int'(bus.process_times), 0);
    chk("rst eps_out", int'(bus.eps_out), 0);
    chk("rst adv", int'(bus.adv), 0);
    chk("rst ret", int'(bus.ret), 0);

    // Table vectors from the reset state.
    for (int i = 0; i < 17; i++) begin
      xact($sformatf("tbl%0d", i), tbl[i].eps, 0, 1'b0);
      chk($sformatf("tbl%0d const esti", i),  got_esti,  tbl[i].esti);
      chk($sformatf("tbl%0d const eo", i),    got_eo,    tbl[i].eo);
      chk($sformatf("tbl%0d const adv", i),   got_adv,   tbl[i].adv);
      chk($sformatf("tbl%0d const ret", i),   got_ret,   tbl[i].ret);
      chk($sformatf("tbl%0d const times", i), got_times, tbl[i].times);
    end

    // Randomized segments with random output stalls.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) e = bnd[$urandom_range(0, 6)];
      else e = int'($urandom_range(0, 65535)) - 32768;
      xact($sformatf("rnd%0d", i), e, int'($urandom_range(0, 3)), 1'b0);
    end

    // Backpressure: result held 5 cycles while eps_valid stays high.
    xact("bp", 8000, 5, 1'b1);
    xact("bp_after", 100, 0, 1'b0);

    // Walk the index down to 0, then wrap below and above.
    guard = 0;
    while (ref_esti != 0 && guard < 800) begin
      xact("walk", -20000, 0, 1'b0);
      guard++;
    end
    chk("walk reached 0", ref_esti, 0);
    xact("wrap_dn", -17000, 0, 1'b0);
    chk("wrap_dn esti", got_esti, 2047);
    chk("wrap_dn eps_out", got_eo, 15768);
    chk("wrap_dn ret", got_ret, 1);
    chk("wrap_dn next", int'(bus.esti_index_next), 1023);
    chk("wrap_dn interp", int'(bus.interp_index), 2043);
    xact("wrap_up", 20000, 0, 1'b0);
    chk("wrap_up esti", got_esti, 0);

    // clr mid-EVAL discards the in-flight segment.
    @(negedge clk);
    bus.eps_valid = 1'b1; bus.eps_in = 16'(20000);
    @(negedge clk);
    bus.eps_valid = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr eps_ready", int'(bus.eps_ready), 1);
    chk("clr out_valid", int'(bus.out_valid), 0);
    chk("clr esti", int'(bus.esti_index), 512);
    chk("clr times", int'(bus.process_times), 0);
    quiet_check("clr", 6);
    ref_esti = 512; ref_times = 0;

    // clr wins over a simultaneous accept.
    @(negedge clk);
    bus.eps_valid = 1'b1; bus.eps_in = 16'(20000); clr = 1'b1;
    @(negedge clk);
    bus.eps_valid = 1'b0; clr = 1'b0;
    chk("clr_acc eps_ready", int'(bus.eps_ready), 1);
    quiet_check("clr_acc", 6);
    chk("clr_acc times", int'(bus.process_times), 0);

    // Build up state, then async rst mid-EVAL.
    for (int i = 0; i < 11; i++) xact("pre_rst", 20000, 0, 1'b0);
    chk("pre_rst esti", got_esti, 513);
    @(negedge clk);
    bus.eps_valid = 1'b1; bus.eps_in = 16'(-20000);
    @(negedge clk);
    bus.eps_valid = 1'b0; rst = 1'b1;
    #1;
    chk("arst esti", int'(bus.esti_index), 512);
    chk("arst times", int'(bus.process_times), 0);
    chk("arst out_valid", int'(bus.out_valid), 0);
    chk("arst eps_ready", int'(bus.eps_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    quiet_check("arst", 6);
    ref_esti = 512; ref_times = 0;
    xact("post_rst", 20000, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
